// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state encoding for the conv frame sequencer
package conv_pkg;

    localparam int WIDTH     = 32;
    localparam int HEIGHT    = 32;
    localparam int K         = 3;
    localparam int OUT_W     = WIDTH - K + 1;
    localparam int OUT_H     = HEIGHT - K + 1;
    localparam int PIX_TOTAL = OUT_W * OUT_H;

    // Counter widths; a single-valued counter still needs one bit
    localparam int K_W  = (K > 1)     ? $clog2(K)     : 1;
    localparam int OC_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OR_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

endpackage

// File: rtl/conv_win_counter.sv
// rtl/conv_win_counter.sv - nested kernel/output position counters for the 3x3 window walk
module conv_win_counter
    import conv_pkg::*;
(
    input  logic            clk,
    input  logic            rstb,
    input  logic            clr,
    input  logic            en,
    output logic [OR_W-1:0] out_r,
    output logic [OC_W-1:0] out_c,
    output logic [K_W-1:0]  kr,
    output logic [K_W-1:0]  kc,
    output logic            at_tap_first,
    output logic            at_tap_last,
    output logic            at_frame_last
);

    logic kc_end;
    logic kr_end;
    logic oc_end;
    logic or_end;

    assign kc_end = (kc == K_W'(K - 1));
    assign kr_end = (kr == K_W'(K - 1));
    assign oc_end = (out_c == OC_W'(OUT_W - 1));
    assign or_end = (out_r == OR_W'(OUT_H - 1));

    assign at_tap_first  = (kr == '0) && (kc == '0);
    assign at_tap_last   = kc_end && kr_end;
    assign at_frame_last = at_tap_last && oc_end && or_end;

    // kc innermost, then kr, out_c, out_r; each wraps and carries into the next-outer one
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            kc    <= '0;
            kr    <= '0;
            out_c <= '0;
            out_r <= '0;
        end else if (clr) begin
            kc    <= '0;
            kr    <= '0;
            out_c <= '0;
            out_r <= '0;
        end else if (en) begin
            kc <= kc_end ? '0 : kc + 1'b1;
            if (kc_end) begin
                kr <= kr_end ? '0 : kr + 1'b1;
            end
            if (kc_end && kr_end) begin
                out_c <= oc_end ? '0 : out_c + 1'b1;
            end
            if (kc_end && kr_end && oc_end) begin
                out_r <= or_end ? '0 : out_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - frame sequencer issuing 3x3 tap reads and MAC-valid pulses
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    input  logic              write_ready,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              tap_first,
    output logic              tap_last,
    output logic              conv_valid,
    output logic [ADDR_W-1:0] pix_cnt
);

    conv_state_t state;
    conv_state_t state_nxt;

    logic [OR_W-1:0]     out_r;
    logic [OC_W-1:0]     out_c;
    logic [K_W-1:0]      kr;
    logic [K_W-1:0]      kc;
    logic                at_tap_first;
    logic                at_tap_last;
    logic                at_frame_last;
    logic                frame_clr;
    logic [ADDR_W-1:0]   img_row;
    logic [ADDR_W-1:0]   img_col;
    logic [PIPE_LAT-1:0] vld_sr;
    logic [PIPE_LAT-1:0] vld_nxt;

    assign frame_clr = (state == ST_IDLE) && start;

    conv_win_counter u_win (
        .clk          (clk),
        .rstb         (rstb),
        .clr          (frame_clr),
        .en           (rd_en),
        .out_r        (out_r),
        .out_c        (out_c),
        .kr           (kr),
        .kc           (kc),
        .at_tap_first (at_tap_first),
        .at_tap_last  (at_tap_last),
        .at_frame_last(at_frame_last)
    );

    // Address straight from the registered counters so it lines up with rd_en
    assign img_row   = ADDR_W'(out_r) + ADDR_W'(kr);
    assign img_col   = ADDR_W'(out_c) + ADDR_W'(kc);
    assign rd_addr   = img_row * ADDR_W'(WIDTH) + img_col;
    assign tap_first = rd_en && at_tap_first;
    assign tap_last  = rd_en && at_tap_last;

    // Shift-register contents after this cycle's shift; drain ends once it will be empty
    if (PIPE_LAT == 1) begin : g_vld_one
        assign vld_nxt = tap_last;
    end else begin : g_vld_multi
        assign vld_nxt = {vld_sr[PIPE_LAT-2:0], tap_last};
    end

    assign conv_valid = vld_sr[PIPE_LAT-1];

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN after the frame's final tap, leave DRAIN with the last conv_valid
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (rd_en && at_frame_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (vld_nxt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: a pixel may only begin when the writer is ready; its later taps never stall
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        rd_en = 1'b0;
        case (state)
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = !at_tap_first || write_ready;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Valid pipeline modelling the MAC latency from last tap to result
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= vld_nxt;
        end
    end

    // Output pixel count, restarted per frame and saturating at the frame total
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pix_cnt <= '0;
        end else if (frame_clr) begin
            pix_cnt <= '0;
        end else if (conv_valid && (pix_cnt != ADDR_W'(PIX_TOTAL))) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed self-checking bench for conv_seq_ctrl
module tb_conv_seq_ctrl;

    localparam int AW = 10;

    logic          clk;
    logic          rstb;
    logic          start;
    logic          write_ready;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          tap_first;
    logic          tap_last;
    logic          conv_valid;
    logic [AW-1:0] pix_cnt;

    int n_cmp;
    int n_bad;
    int cyc;

    conv_seq_ctrl #(.ADDR_W(AW), .PIPE_LAT(2)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .start      (start),
        .write_ready(write_ready),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .tap_first  (tap_first),
        .tap_last   (tap_last),
        .conv_valid (conv_valid),
        .pix_cnt    (pix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected tap address for unstalled RUN cycle c of a 32x32 image, 30x30 output
    function automatic logic [AW-1:0] model_addr(input int c);
        int p, t, orow, ocol;
        p    = c / 9;
        t    = c % 9;
        orow = p / 30;
        ocol = p % 30;
        return AW'((orow + t / 3) * 32 + ocol + t % 3);
    endfunction

    // Drive inputs for the next cycle at the falling edge, then settle
    task automatic step(input logic wr, input logic st);
        @(negedge clk);
        write_ready = wr;
        start       = st;
        #1;
        cyc++;
    endtask

    task automatic start_frame();
        step(1'b1, 1'b1);
        cyc = -1;
    endtask

    task automatic finish_frame(output int n_done, output logic [AW-1:0] pc, output logic to);
        n_done = 0;
        pc     = '0;
        to     = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            step(1'b1, 1'b0);
            if (done) begin
                n_done++;
                pc = pix_cnt;
            end
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstb        = 1'b0;
        start       = 1'b0;
        write_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        n_cmp++; if (rd_addr !== '0) begin n_bad++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        n_cmp++; if ({tap_first, tap_last, conv_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {tap_first, tap_last, conv_valid}); end
        n_cmp++; if (pix_cnt !== '0) begin n_bad++; $display("FAIL reset_pix_cnt got %0d want 0", pix_cnt); end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [AW-1:0] first_taps [9] = '{10'd0, 10'd1, 10'd2, 10'd32, 10'd33, 10'd34, 10'd64, 10'd65, 10'd66};
        int sweep_bad, first_bad, n_valid, n_done, last_valid;
        sweep_bad = 0; first_bad = -1; n_valid = 0; n_done = 0; last_valid = -1;
        start_frame();
        while (cyc < 8103) begin
            step(1'b1, 1'b0);
            if (cyc <= 8) begin
                n_cmp++;
                if (rd_en !== 1'b1 || rd_addr !== first_taps[cyc]) begin
                    n_bad++; $display("FAIL basic_tap%0d got en=%b addr=%0d want en=1 addr=%0d", cyc, rd_en, rd_addr, first_taps[cyc]);
                end
            end
            if (cyc < 8100) begin
                if (rd_en !== 1'b1 || rd_addr !== model_addr(cyc)) begin
                    sweep_bad++; if (first_bad < 0) first_bad = cyc;
                end
            end else if (rd_en !== 1'b0) begin
                sweep_bad++; if (first_bad < 0) first_bad = cyc;
            end
            if (conv_valid === 1'b1) begin n_valid++; last_valid = cyc; end
            if (done === 1'b1) n_done++;
            case (cyc)
                0: begin n_cmp++; if ({tap_first, tap_last} !== 2'b10) begin n_bad++; $display("FAIL basic_first_flags got %b want 10", {tap_first, tap_last}); end end
                8: begin n_cmp++; if ({tap_first, tap_last} !== 2'b01) begin n_bad++; $display("FAIL basic_last_flags got %b want 01", {tap_first, tap_last}); end end
                9: begin n_cmp++; if (rd_addr !== 10'd1 || tap_first !== 1'b1 || conv_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pix1_start got addr=%0d first=%b valid=%b want 1 1 0", rd_addr, tap_first, conv_valid); end end
                10: begin n_cmp++; if (conv_valid !== 1'b1) begin n_bad++; $display("FAIL basic_conv_valid got %b want 1", conv_valid); end end
                261: begin n_cmp++; if (rd_addr !== 10'd29 || tap_first !== 1'b1) begin n_bad++; $display("FAIL rowwrap_pix29 got addr=%0d first=%b want 29 1", rd_addr, tap_first); end end
                270: begin n_cmp++; if (rd_addr !== 10'd32 || tap_first !== 1'b1) begin n_bad++; $display("FAIL rowwrap_pix30 got addr=%0d first=%b want 32 1", rd_addr, tap_first); end end
                8091: begin n_cmp++; if (rd_addr !== 10'd957 || tap_first !== 1'b1) begin n_bad++; $display("FAIL end_last_pix_start got addr=%0d first=%b want 957 1", rd_addr, tap_first); end end
                8099: begin n_cmp++; if (rd_addr !== 10'd1023 || tap_last !== 1'b1) begin n_bad++; $display("FAIL end_last_tap got addr=%0d last=%b want 1023 1", rd_addr, tap_last); end end
                8102: begin n_cmp++; if (done !== 1'b1 || busy !== 1'b1 || pix_cnt !== 10'd900) begin n_bad++; $display("FAIL end_done got done=%b busy=%b pix=%0d want 1 1 900", done, busy, pix_cnt); end end
                8103: begin n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL end_idle got busy=%b done=%b want 0 0", busy, done); end end
                default: ;
            endcase
        end
        n_cmp++; if (sweep_bad !== 0) begin n_bad++; $display("FAIL basic_addr_sweep got %0d bad cycles (first %0d) want 0", sweep_bad, first_bad); end
        n_cmp++; if (n_valid !== 900 || last_valid !== 8101) begin n_bad++; $display("FAIL basic_valid_count got %0d last@%0d want 900 last@8101", n_valid, last_valid); end
        n_cmp++; if (n_done !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", n_done); end
    endtask

    task automatic test_backpressure();
        logic wr;
        int bad_taps, n_done;
        logic [AW-1:0] pc;
        logic to;
        bad_taps = 0;
        start_frame();
        for (int c = 0; c <= 14; c++) begin
            wr = !((c >= 3 && c <= 5) || (c >= 9 && c <= 12));
            step(wr, 1'b0);
            if (c <= 8 && (rd_en !== 1'b1 || rd_addr !== model_addr(c))) bad_taps++;
            if (c >= 9 && c <= 12) begin
                n_cmp++; if (rd_en !== 1'b0) begin n_bad++; $display("FAIL bp_stall_c%0d got rd_en=%b want 0", c, rd_en); end
            end
            if (c == 10) begin
                n_cmp++; if (conv_valid !== 1'b1) begin n_bad++; $display("FAIL bp_conv_valid got %b want 1", conv_valid); end
            end
            if (c == 13) begin
                n_cmp++; if (rd_en !== 1'b1 || rd_addr !== 10'd1 || tap_first !== 1'b1) begin n_bad++; $display("FAIL bp_resume got en=%b addr=%0d first=%b want 1 1 1", rd_en, rd_addr, tap_first); end
            end
            if (c == 14) begin
                n_cmp++; if (rd_addr !== 10'd2) begin n_bad++; $display("FAIL bp_resume_tap1 got addr=%0d want 2", rd_addr); end
            end
        end
        n_cmp++; if (bad_taps !== 0) begin n_bad++; $display("FAIL bp_pix0_taps got %0d bad want 0", bad_taps); end
        finish_frame(n_done, pc, to);
        n_cmp++; if (to !== 1'b0 || n_done !== 1 || pc !== 10'd900) begin n_bad++; $display("FAIL bp_frame_end got timeout=%b dones=%0d pix=%0d want 0 1 900", to, n_done, pc); end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        logic [AW-1:0] pc;
        logic to;
        start_frame();
        for (int c = 0; c <= 120; c++) begin
            step(1'b1, (c >= 100 && c <= 102));
            if (c == 101) begin
                n_cmp++; if (rd_addr !== 10'd13) begin n_bad++; $display("FAIL swb_c101 got addr=%0d want 13", rd_addr); end
            end
            if (c == 103) begin
                n_cmp++; if (rd_addr !== 10'd44) begin n_bad++; $display("FAIL swb_c103 got addr=%0d want 44", rd_addr); end
            end
            if (c == 120) begin
                n_cmp++; if (pix_cnt !== 10'd13) begin n_bad++; $display("FAIL swb_pix_cnt got %0d want 13", pix_cnt); end
            end
        end
        finish_frame(n_done, pc, to);
        n_cmp++; if (to !== 1'b0 || n_done !== 1 || pc !== 10'd900) begin n_bad++; $display("FAIL swb_frame_end got timeout=%b dones=%0d pix=%0d want 0 1 900", to, n_done, pc); end
        repeat (5) step(1'b1, 1'b0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL swb_no_restart got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int n_done;
        logic [AW-1:0] pc;
        logic to;
        logic saw_done;
        saw_done = 1'b0;
        start_frame();
        for (int c = 0; c <= 499; c++) step(1'b1, 1'b0);
        n_cmp++; if (pix_cnt !== 10'd55) begin n_bad++; $display("FAIL rst_pre_pix_cnt got %0d want 55", pix_cnt); end
        @(negedge clk);
        rstb = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, rd_en, tap_first, tap_last, conv_valid} !== 6'b0 || rd_addr !== '0 || pix_cnt !== '0) begin
            n_bad++; $display("FAIL rst_async_clear got busy=%b done=%b en=%b addr=%0d valid=%b pix=%0d want all 0", busy, done, rd_en, rd_addr, conv_valid, pix_cnt);
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        rstb = 1'b1;
        #1;
        if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done got activity=%b want 0", saw_done); end
        start_frame();
        step(1'b1, 1'b0);
        n_cmp++; if (rd_addr !== '0 || tap_first !== 1'b1 || pix_cnt !== '0 || busy !== 1'b1) begin n_bad++; $display("FAIL rst_fresh_start got addr=%0d first=%b pix=%0d busy=%b want 0 1 0 1", rd_addr, tap_first, pix_cnt, busy); end
        finish_frame(n_done, pc, to);
        n_cmp++; if (to !== 1'b0 || n_done !== 1 || pc !== 10'd900) begin n_bad++; $display("FAIL rst_frame_end got timeout=%b dones=%0d pix=%0d want 0 1 900", to, n_done, pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Frame sequencer for the 3x3 convolution path.
- On `start`, walks every output position of a WIDTH x HEIGHT input image. For each position it issues the 9 tap read addresses, in row-major order, to the input image memory and the conv MAC datapath.
- Pulses `conv_valid` to the output-buffer writer once per finished output pixel, PIPE_LAT cycles after the last tap.
- Honours the writer's `write_ready` backpressure at pixel boundaries and reports frame completion.

Parameters:
- WIDTH, 32, input image width in pixels
- HEIGHT, 32, input image height in pixels
- K, 3, kernel size; OUT_W = WIDTH-K+1, OUT_H = HEIGHT-K+1 (derived)
- ADDR_W, 10, input memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- PIPE_LAT, 2, cycles from last-tap issue to MAC result valid (>=1)

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- start  in  1  frame start request, sampled in IDLE only
- write_ready  in  1  output writer can accept pixels
- busy  out  1  high from the first RUN cycle through the DONE cycle
- done  out  1  one-cycle pulse, frame complete
- rd_en  out  1  tap read issued this cycle
- rd_addr  out  ADDR_W  input memory address of the current tap
- tap_first  out  1  current tap is kernel (0,0); clears the MAC accumulator
- tap_last  out  1  current tap is kernel (K-1,K-1)
- conv_valid  out  1  one-cycle pulse, MAC output pixel valid for the writer
- pix_cnt  out  ADDR_W  number of conv_valid pulses in the current frame

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; valid shift register cleared. Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Reset is asynchronous on all registers; there is no memory inside this block.
- States:
  - IDLE: on start=1, clear pix_cnt and row/col/tap counters, go to RUN.
  - RUN: issue taps as described below. After tap_last of output (OUT_H-1, OUT_W-1) is issued, go to DRAIN.
  - DRAIN: issue nothing. Go to DONE when the valid shift register is empty (last conv_valid has fired).
  - DONE: done=1 and busy=1 for this single cycle, then return to IDLE.
- start is ignored outside IDLE.
- Counters: out_r 0..OUT_H-1, out_c 0..OUT_W-1, kr 0..K-1, kc 0..K-1.
  - Order: kc is innermost, then kr, then out_c, then out_r.
  - All counters wrap to 0 on terminal count; the next-outer counter carries.
- Address: rd_addr = (out_r+kr)*WIDTH + (out_c+kc). Computed from registered counters, combinationally or registered so that it aligns with rd_en. Width ADDR_W, no overflow for legal parameters.
- Issue rule in RUN:
  - rd_en=1 when the pixel boundary condition is met: (kr,kc) != (0,0), OR write_ready=1.
  - Once tap 0 of a pixel issues, the remaining K*K-1 taps issue on consecutive cycles regardless of write_ready.
  - write_ready=0 at a pixel boundary stalls: rd_en=0 and counters hold.
- tap_first = rd_en & (kr==0) & (kc==0). tap_last = rd_en & (kr==K-1) & (kc==K-1).
- Valid pipeline:
  - A PIPE_LAT-deep shift register is fed by tap_last; conv_valid is its output.
  - pix_cnt increments on conv_valid and saturates at OUT_W*OUT_H.
- Unstalled throughput: one output pixel per K*K cycles; a full default frame is 900*9 = 8100 issue cycles.
- busy = (state != IDLE).

Decomposition:
- Package conv_pkg:
  - Constants WIDTH, HEIGHT, K, OUT_W, OUT_H, PIX_TOTAL = OUT_W*OUT_H.
  - State encoding constants for IDLE, RUN, DRAIN, DONE.
- Sub-module conv_win_counter: nested kc/kr/out_c/out_r counters with an enable input. Outputs the counter values, tap_first/tap_last flags, and a frame_last_tap flag.
- conv_seq_ctrl keeps the FSM, address arithmetic, valid shift register and pix_cnt.

Test Plan:
- Basic frame:
  - Stimulus: write_ready=1, start pulse in IDLE; RUN cycle 0 is the cycle after start.
  - Required: cycles 0..8 give rd_addr 0,1,2,32,33,34,64,65,66. tap_first at cycle 0, tap_last at cycle 8, conv_valid at cycle 10. Second pixel starts at cycle 9 with rd_addr 1.
- Row wrap:
  - Stimulus: run to pixel 29.
  - Required: its taps start at addr 29; pixel 30 starts at addr 32 (out_r=1, out_c=0).
- Frame end:
  - Required: last pixel taps run 957..1023 ending at cycle 8099. Last conv_valid at cycle 8101, done pulse at cycle 8102, pix_cnt=900, busy low at 8103.
- Backpressure:
  - Stimulus: drop write_ready during taps 3..5 of pixel 0, and for cycles 9..12.
  - Required: pixel 0 taps are uninterrupted. rd_en=0 on cycles 9..12; pixel 1 tap 0 (addr 1) issues at cycle 13.
- Start while busy:
  - Stimulus: pulse start mid-RUN.
  - Required: no counter change; the frame finishes normally with a single done pulse.
- Reset mid-frame:
  - Stimulus: rstb low at cycle 500, high later, then new start.
  - Required: all outputs 0 immediately with no done pulse. The fresh frame begins at rd_addr 0 with pix_cnt=0.
